// File: rtl/axis_packet_fifo_if.sv
// AXI-Stream beat bundle (valid/ready/data/last) shared by the write and read
// sides of axis_packet_fifo.
interface axis_packet_fifo_if #(
    parameter int WIDTH = 8
) ();
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic             last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/axis_packet_fifo.sv
// Single-clock AXI-Stream FIFO with registered output, exact occupancy count,
// threshold flags, synchronous flush and optional store-and-forward packet mode.
//
// state       | meaning
// ------------+------------------------------------------------------------
// REL_IDLE    | normal operation; in packet mode only complete packets leave
// REL_ACTIVE  | forced release of an oversize packet; beats drain as a stream
module axis_packet_fifo #(
    parameter int WIDTH        = 8,
    parameter int DEPTH_BITS   = 7,
    parameter bit PACKET_MODE  = 1'b0,
    parameter int AFULL_LEVEL  = (1 << DEPTH_BITS) - 4,
    parameter int AEMPTY_LEVEL = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    axis_packet_fifo_if.slave     s_axis,
    axis_packet_fifo_if.master    m_axis,
    output logic [DEPTH_BITS:0]   load,
    output logic [DEPTH_BITS:0]   pkt_count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  oversize
);
    localparam int                  DEPTH    = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] DEPTH_L  = DEPTH[DEPTH_BITS:0];
    localparam logic [DEPTH_BITS:0] AFULL_L  = AFULL_LEVEL[DEPTH_BITS:0];
    localparam logic [DEPTH_BITS:0] AEMPTY_L = AEMPTY_LEVEL[DEPTH_BITS:0];
    localparam logic [DEPTH_BITS:0] CNT_ONE  = {{DEPTH_BITS{1'b0}}, 1'b1};
    localparam logic [DEPTH_BITS-1:0] PTR_ONE = {{(DEPTH_BITS-1){1'b0}}, 1'b1};

    typedef enum logic {REL_IDLE, REL_ACTIVE} rel_state_t;

    logic [WIDTH:0]          mem_q [DEPTH];
    logic [DEPTH_BITS-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]     load_q, load_d, pkt_q, pkt_d, mem_cnt;
    logic                    out_vld_q, out_vld_d;
    logic [WIDTH-1:0]        data_q, data_d;
    logic                    last_q, last_d;
    logic                    pkt_avail_q, pkt_avail_d;
    logic                    afull_q, afull_d, aempty_q, aempty_d;
    logic                    oversize_q, oversize_d;
    rel_state_t              rel_q, rel_d;

    logic s_ready_c, m_valid_c, push, pop, refill, pkt_inc, pkt_dec;

    assign s_ready_c = (load_q != DEPTH_L);
    // In packet mode the head may only leave once its packet is complete,
    // unless an oversize packet is being forced out.
    assign m_valid_c = out_vld_q & (!PACKET_MODE | pkt_avail_q | (rel_q == REL_ACTIVE));
    assign push      = s_axis.valid & s_ready_c;
    assign pop       = m_valid_c & m_axis.ready;
    assign mem_cnt   = load_q - {{DEPTH_BITS{1'b0}}, out_vld_q};
    assign refill    = (mem_cnt != '0) & (!out_vld_q | pop);
    assign pkt_inc   = PACKET_MODE & push & s_axis.last;
    assign pkt_dec   = PACKET_MODE & pop & last_q & (pkt_q != '0);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        load_d      = load_q;
        pkt_d       = pkt_q;
        out_vld_d   = out_vld_q;
        data_d      = data_q;
        last_d      = last_q;
        rel_d       = rel_q;
        oversize_d  = 1'b0;
        pkt_avail_d = 1'b0;
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            load_d    = '0;
            pkt_d     = '0;
            out_vld_d = 1'b0;
            rel_d     = REL_IDLE;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (refill) begin
                {last_d, data_d} = mem_q[rd_ptr_q];
                rd_ptr_d         = rd_ptr_q + PTR_ONE;
                out_vld_d        = 1'b1;
            end else if (pop) begin
                out_vld_d = 1'b0;
            end
            case ({push, pop})
                2'b10:   load_d = load_q + CNT_ONE;
                2'b01:   load_d = load_q - CNT_ONE;
                default: load_d = load_q;
            endcase
            if (pkt_inc && !pkt_dec)      pkt_d = pkt_q + CNT_ONE;
            else if (pkt_dec && !pkt_inc) pkt_d = pkt_q - CNT_ONE;
            case (rel_q)
                REL_IDLE: begin
                    if (PACKET_MODE && load_q == DEPTH_L && pkt_q == '0) begin
                        rel_d      = REL_ACTIVE;
                        oversize_d = 1'b1;
                    end
                end
                REL_ACTIVE: begin
                    if (pop && last_q) rel_d = REL_IDLE;
                end
                default: rel_d = REL_IDLE;
            endcase
            // Availability rises a cycle after the packet completes but falls
            // immediately when the last complete packet leaves.
            pkt_avail_d = (pkt_q != '0) && (pkt_d != '0);
        end
        afull_d  = (load_d >= AFULL_L);
        aempty_d = (load_d <= AEMPTY_L);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            load_q      <= '0;
            pkt_q       <= '0;
            out_vld_q   <= 1'b0;
            data_q      <= '0;
            last_q      <= 1'b0;
            pkt_avail_q <= 1'b0;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            oversize_q  <= 1'b0;
            rel_q       <= REL_IDLE;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            load_q      <= load_d;
            pkt_q       <= pkt_d;
            out_vld_q   <= out_vld_d;
            data_q      <= data_d;
            last_q      <= last_d;
            pkt_avail_q <= pkt_avail_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
            oversize_q  <= oversize_d;
            rel_q       <= rel_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= {s_axis.last, s_axis.data};
    end

    assign s_axis.ready = s_ready_c;
    assign m_axis.valid = m_valid_c;
    assign m_axis.data  = data_q;
    assign m_axis.last  = last_q;
    assign load         = load_q;
    assign pkt_count    = pkt_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign oversize     = oversize_q;
endmodule

// File: tb/tb_axis_packet_fifo.sv
// Bench for axis_packet_fifo: a stream instance driven from a vector table and a
// packet-mode instance driven by hand sequences, both with scoreboards on data.
module tb_axis_packet_fifo;
    logic clk  = 1'b0;
    logic rstn = 1'b1;
    logic flush_a = 1'b0, flush_b = 1'b0;
    logic [3:0] load_a, pkt_a, load_b, pkt_b;
    logic afull_a, aempty_a, ovs_a, afull_b, aempty_b, ovs_b;
    int n_cmp = 0;
    int n_bad = 0;
    int ov_cnt = 0;
    logic [8:0] q_a[$];
    logic [8:0] q_b[$];

    always #5 clk = ~clk;

    axis_packet_fifo_if #(.WIDTH(8)) sa ();
    axis_packet_fifo_if #(.WIDTH(8)) ma ();
    axis_packet_fifo_if #(.WIDTH(8)) sb ();
    axis_packet_fifo_if #(.WIDTH(8)) mb ();

    axis_packet_fifo #(.WIDTH(8), .DEPTH_BITS(3), .PACKET_MODE(1'b0)) dut_a (
        .clk(clk), .rstn(rstn), .flush(flush_a), .s_axis(sa), .m_axis(ma),
        .load(load_a), .pkt_count(pkt_a), .almost_full(afull_a),
        .almost_empty(aempty_a), .oversize(ovs_a));

    axis_packet_fifo #(.WIDTH(8), .DEPTH_BITS(3), .PACKET_MODE(1'b1)) dut_b (
        .clk(clk), .rstn(rstn), .flush(flush_b), .s_axis(sb), .m_axis(mb),
        .load(load_b), .pkt_count(pkt_b), .almost_full(afull_b),
        .almost_empty(aempty_b), .oversize(ovs_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Scoreboards: expected beats enqueued on push, compared on pop.
    always @(negedge clk) begin
        if (!rstn || flush_a) q_a.delete();
        else begin
            if (ma.valid && ma.ready) begin
                if (q_a.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL a_spurious_pop: actual beat %0h required none", {ma.last, ma.data});
                end else chk("a_pop_beat", {ma.last, ma.data}, q_a.pop_front());
            end
            if (sa.valid && sa.ready) q_a.push_back({sa.last, sa.data});
        end
    end

    always @(negedge clk) begin
        if (!rstn || flush_b) q_b.delete();
        else begin
            if (mb.valid && mb.ready) begin
                if (q_b.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL b_spurious_pop: actual beat %0h required none", {mb.last, mb.data});
                end else chk("b_pop_beat", {mb.last, mb.data}, q_b.pop_front());
            end
            if (sb.valid && sb.ready) q_b.push_back({sb.last, sb.data});
            if (ovs_b) ov_cnt++;
        end
    end

    typedef struct {
        logic       sv;
        logic [7:0] sd;
        logic       mr;
        int         ld;
        logic       mv;
        logic       srdy;
        logic       af;
        logic       ae;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic sv, input logic [7:0] sd, input logic mr,
                                input int ld, input logic mv);
        vec_t v;
        v.sv = sv; v.sd = sd; v.mr = mr; v.ld = ld; v.mv = mv;
        v.srdy = (ld != 8);
        v.af = (ld >= 4);
        v.ae = (ld <= 4);
        vecs.push_back(v);
    endfunction

    task automatic step_b(input logic v, input logic [7:0] d, input logic l,
                          input logic r, input logic f);
        sb.valid = v; sb.data = d; sb.last = l; mb.ready = r; flush_b = f;
        @(posedge clk); #1;
    endtask

    task automatic chk_rst(input string n, input logic sr, input logic mv, input logic [7:0] md,
                           input logic ml, input logic [3:0] ld, input logic [3:0] pk,
                           input logic af, input logic ae, input logic ov);
        chk({n, "_rst_s_ready"}, sr, 1);
        chk({n, "_rst_m_valid"}, mv, 0);
        chk({n, "_rst_m_data"}, md, 0);
        chk({n, "_rst_m_last"}, ml, 0);
        chk({n, "_rst_load"}, ld, 0);
        chk({n, "_rst_pkt"}, pk, 0);
        chk({n, "_rst_afull"}, af, 0);
        chk({n, "_rst_aempty"}, ae, 1);
        chk({n, "_rst_oversize"}, ov, 0);
    endtask

    initial begin
        sa.valid = 0; sa.data = 0; sa.last = 0; ma.ready = 0;
        sb.valid = 0; sb.data = 0; sb.last = 0; mb.ready = 0;
        #1 rstn = 1'b0;
        #1;
        chk_rst("a", sa.ready, ma.valid, ma.data, ma.last, load_a, pkt_a, afull_a, aempty_a, ovs_a);
        chk_rst("b", sb.ready, mb.valid, mb.data, mb.last, load_b, pkt_b, afull_b, aempty_b, ovs_b);
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;

        // Stream instance: fill to full, refused push while full, drain in order.
        for (int k = 1; k <= 8; k++) add(1, 8'h10 + 8'(k - 1), 0, k, k >= 2);
        add(1, 8'h99, 0, 8, 1);
        for (int j = 1; j <= 8; j++) add(0, 8'h00, 1, 8 - j, (8 - j) > 0);
        // Continuous push/pop across three pointer wraps.
        for (int k = 1; k <= 24; k++) add(1, 8'h20 + 8'(k), 1, (k < 2) ? k : 2, k >= 2);
        add(0, 8'h00, 1, 1, 1);
        add(0, 8'h00, 1, 0, 0);
        // Push and pop together at DEPTH-1.
        for (int k = 1; k <= 7; k++) add(1, 8'h40 + 8'(k), 0, k, k >= 2);
        add(1, 8'h48, 1, 7, 1);
        for (int j = 1; j <= 7; j++) add(0, 8'h00, 1, 7 - j, (7 - j) > 0);

        for (int i = 0; i < vecs.size(); i++) begin
            sa.valid = vecs[i].sv; sa.data = vecs[i].sd; sa.last = 1'b0; ma.ready = vecs[i].mr;
            @(posedge clk); #1;
            chk($sformatf("a_load[%0d]", i), load_a, vecs[i].ld);
            chk($sformatf("a_s_ready[%0d]", i), sa.ready, vecs[i].srdy);
            chk($sformatf("a_m_valid[%0d]", i), ma.valid, vecs[i].mv);
            chk($sformatf("a_afull[%0d]", i), afull_a, vecs[i].af);
            chk($sformatf("a_aempty[%0d]", i), aempty_a, vecs[i].ae);
            chk($sformatf("a_pkt[%0d]", i), pkt_a, 0);
        end
        sa.valid = 0; ma.ready = 0;
        chk("a_scoreboard_drained", q_a.size(), 0);

        // Packet mode: three-beat packet is held until complete.
        step_b(1, 8'hA0, 0, 1, 0);
        step_b(1, 8'hA1, 0, 1, 0);
        step_b(1, 8'hA2, 1, 1, 0);
        chk("b_mvalid_after_last_push", mb.valid, 0);
        chk("b_pkt_one", pkt_b, 1);
        step_b(0, 8'h00, 0, 1, 0);
        chk("b_mvalid_released", mb.valid, 1);
        step_b(0, 8'h00, 0, 1, 0);
        step_b(0, 8'h00, 0, 1, 0);
        chk("b_head_last", {mb.last, mb.data}, {1'b1, 8'hA2});
        step_b(0, 8'h00, 0, 1, 0);
        chk("b_pkt_back_zero", pkt_b, 0);
        chk("b_load_back_zero", load_b, 0);
        chk("b_mvalid_drained", mb.valid, 0);

        // Oversize: fill with no last, forced release, drain.
        for (int k = 0; k < 8; k++) step_b(1, 8'hC0 + 8'(k), 0, 0, 0);
        chk("b_full_load", load_b, 8);
        chk("b_full_s_ready", sb.ready, 0);
        chk("b_full_m_valid", mb.valid, 0);
        chk("b_full_oversize", ovs_b, 0);
        step_b(0, 8'h00, 0, 0, 0);
        chk("b_oversize_pulse", ovs_b, 1);
        chk("b_release_m_valid", mb.valid, 1);
        step_b(0, 8'h00, 0, 1, 0);
        chk("b_oversize_cleared", ovs_b, 0);
        chk("b_s_ready_after_pop", sb.ready, 1);
        repeat (7) step_b(0, 8'h00, 0, 1, 0);
        chk("b_release_drained_load", load_b, 0);
        chk("b_release_drained_mvalid", mb.valid, 0);
        chk("b_oversize_count", ov_cnt, 1);
        step_b(1, 8'hB0, 0, 1, 0);
        step_b(1, 8'hB1, 1, 1, 0);
        step_b(0, 8'h00, 0, 1, 0);
        step_b(0, 8'h00, 0, 1, 0);
        chk("b_release_pkt_zero", pkt_b, 0);
        chk("b_release_load_zero", load_b, 0);
        // Release must be over: a lone partial beat is held back.
        step_b(1, 8'hE9, 0, 1, 0);
        repeat (4) step_b(0, 8'h00, 0, 1, 0);
        chk("b_partial_held", mb.valid, 0);
        chk("b_partial_load", load_b, 1);
        step_b(0, 8'h00, 0, 0, 1);
        chk("b_flush1_load", load_b, 0);

        // Flush with a complete packet plus a partial one held.
        step_b(1, 8'hD0, 0, 0, 0);
        step_b(1, 8'hD1, 1, 0, 0);
        step_b(1, 8'hE0, 0, 0, 0);
        step_b(1, 8'hE1, 0, 0, 0);
        step_b(1, 8'hE2, 0, 0, 0);
        chk("b_pre_flush_load", load_b, 5);
        chk("b_pre_flush_pkt", pkt_b, 1);
        chk("b_pre_flush_mvalid", mb.valid, 1);
        chk("b_pre_flush_afull", afull_b, 1);
        chk("b_pre_flush_aempty", aempty_b, 0);
        step_b(1, 8'h77, 0, 1, 1);
        chk("b_flush_load", load_b, 0);
        chk("b_flush_mvalid", mb.valid, 0);
        chk("b_flush_s_ready", sb.ready, 1);
        chk("b_flush_pkt", pkt_b, 0);
        chk("b_flush_afull", afull_b, 0);
        chk("b_flush_aempty", aempty_b, 1);
        step_b(1, 8'hF0, 0, 1, 0);
        step_b(1, 8'hF1, 1, 1, 0);
        repeat (4) step_b(0, 8'h00, 0, 1, 0);
        chk("b_post_flush_load", load_b, 0);
        chk("b_post_flush_pkt", pkt_b, 0);
        chk("b_scoreboard_drained", q_b.size(), 0);
        mb.ready = 0;

        // Asynchronous reset in the middle of a burst.
        sa.valid = 1; sa.data = 8'h55; ma.ready = 0;
        sb.valid = 1; sb.data = 8'h66; sb.last = 0;
        repeat (3) @(posedge clk);
        #3;
        chk("a_burst_load", load_a, 3);
        rstn = 1'b0;
        #1;
        chk_rst("a_async", sa.ready, ma.valid, ma.data, ma.last, load_a, pkt_a, afull_a, aempty_a, ovs_a);
        chk_rst("b_async", sb.ready, mb.valid, mb.data, mb.last, load_b, pkt_b, afull_b, aempty_b, ovs_b);
        sa.valid = 0; sb.valid = 0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("a_post_reset_load", load_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axis_packet_fifo.md
# axis_packet_fifo

Single-clock AXI-Stream FIFO that replaces the dual-pointer stream FIFO wherever producer and consumer share one clock. It adds a `last` sideband, an optional store-and-forward packet mode, programmable almost-full/almost-empty flags, a synchronous flush, and an exact occupancy count. All `DEPTH` entries are usable. It sits between DMA/peripheral stream sources (UART, SD, Ethernet MAC) and their bus-side consumers.

## Interface
- `WIDTH`, 8: data bits per beat.
- `DEPTH_BITS`, 7: log2 of capacity; `DEPTH = 1 << DEPTH_BITS` beats, all usable.
- `PACKET_MODE`, 0: 0 = cut-through stream; 1 = store-and-forward on `s_last`.
- `AFULL_LEVEL`, `DEPTH-4`: `almost_full` threshold; legal range 1..DEPTH.
- `AEMPTY_LEVEL`, 4: `almost_empty` threshold; legal range 0..DEPTH-1.

- `clk`  in  1  Single clock. All logic is rising-edge.
- `rstn`  in  1  Asynchronous, active-low reset.
- `flush`  in  1  Synchronous clear.
- `s_valid` in 1, `s_ready` out 1, `s_data` in WIDTH, `s_last` in 1: write side.
- `m_valid` out 1, `m_ready` in 1, `m_data` out WIDTH, `m_last` out 1: read side. `m_data` and `m_last` are registered.
- `load`  out  DEPTH_BITS+1  Beats held, 0..DEPTH.
- `pkt_count`  out  DEPTH_BITS+1  Complete packets held. Held at 0 when `PACKET_MODE=0`.
- `almost_full`, `almost_empty`  out  1  Threshold flags.
- `oversize`  out  1  One-cycle pulse on a forced packet release.

## Operation
- Push = `s_valid & s_ready`. Pop = `m_valid & m_ready`.
- `s_data` and `s_last` are stored together. `m_last` is the stored `last` bit of the beat on `m_data`.
- `s_ready = (load != DEPTH)`. It is independent of `s_valid`.
- `load` next value = `load + push - pop`. `load` counts every accepted beat not yet popped, including the beat in the output register.
- The flags are registered from the next value of `load`:
  - `almost_full = (load >= AFULL_LEVEL)`.
  - `almost_empty = (load <= AEMPTY_LEVEL)`.
- Pointers are DEPTH_BITS wide and wrap modulo DEPTH. Full and empty are decided from `load`, never from pointer equality alone.
- Stream mode: `m_valid` is high whenever at least one beat is held and has reached the output register.
- Packet mode:
  - `pkt_count` increments on a push with `s_last=1`.
  - `pkt_count` decrements on a pop with `m_last=1`.
  - When both happen in the same cycle, `pkt_count` is unchanged.
  - `m_valid` is high only while the head beat belongs to a complete packet (`pkt_count > 0`) or release is active.
- Forced release (packet mode only):
  - Trigger: `load == DEPTH`, `pkt_count == 0` and `flush == 0`.
  - Release becomes active. `oversize` pulses for one cycle.
  - While release is active, held beats drain as a stream.
  - Release clears on the edge that pops a beat with `m_last=1`, or on flush or reset.
  - Beats pushed during release are still counted toward `pkt_count` normally.
- Flush:
  - Takes priority over push and pop in the same cycle.
  - Clears pointers, `load`, `pkt_count`, release state and the output register valid bit.
  - Discards any partial packet.
  - Memory contents are not cleared.
- Reset (async, mid-operation legal) forces:
  - `s_ready=1`, `m_valid=0`, `m_data=0`, `m_last=0`, `load=0`, `pkt_count=0`.
  - `almost_full=0`, `almost_empty=1` (for AEMPTY_LEVEL ≥ 0), `oversize=0`.
  - Release is inactive.

## Timing
- Throughput is one push and one pop per cycle, sustained, including at wrap-around.
- Stream latency: a beat pushed at edge N into an empty FIFO gives `m_valid=1` after edge N+1.
- Packet latency: `m_valid=1` after edge N+1, where N is the edge that pushes the `s_last` beat.
- `s_ready` rises in the cycle after the pop edge that drops `load` below DEPTH.
- Push and pop at `load == DEPTH-1`: `load` stays DEPTH-1.
- Push into empty plus simultaneous `m_ready`: no pop that cycle, because `m_valid` is low.
- Output register holds `m_data` and `m_last` stable while `m_valid & !m_ready`.
- `m_valid` never drops without a pop, except on flush or reset.
- Flush at edge N: after edge N, `s_ready=1`, `m_valid=0`, `load=0`.

## Test plan
- Stream, DEPTH_BITS=3: push 8 beats 0x10..0x17 with `m_ready=0`.
  - `load` reaches 8 and `s_ready=0`.
  - `almost_full=1` from the 4th push.
  - Then `m_ready=1` pops 0x10..0x17 in order, one per cycle, and `load` returns to 0.
- Continuous push and pop for 3×DEPTH beats of an incrementing pattern: no bubble after the first `m_valid`, data in order across the pointer wrap, `load` constant.
- Packet mode: push 3 beats with `s_last` on the 3rd.
  - `m_valid` stays 0 until the edge after the 3rd push.
  - `pkt_count` reads 1.
  - The pop of beat 3 shows `m_last=1`, and `pkt_count` returns to 0.
- Packet mode, DEPTH=8: push 8 beats with no `s_last`.
  - `oversize` pulses once.
  - All 8 beats drain.
  - Release clears on the first popped `m_last` beat.
- Flush with 5 beats held and a partial packet pending: the next cycle shows `load=0`, `m_valid=0`, `s_ready=1`, and a new packet passes cleanly.
- Assert `rstn=0` asynchronously mid-burst: all outputs take their reset values without a clock edge.
